// File: rtl/sobel_edge_post.sv
// rtl/sobel_edge_post.sv - Sobel magnitude post-processing: raster tracking, border blanking, threshold, edge count
// Maps each filter output to its raster position, zeroes the border, thresholds and counts edges per frame.

module sobel_edge_post #(
   parameter int SIZE_X = 800,
   parameter int SIZE_Y = 600,
   parameter int LAG    = SIZE_X + 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        sof,
   input  logic        in_valid,
   input  logic [9:0]  in_pix,
   input  logic [9:0]  thresh,
   input  logic        mode,
   output logic        out_valid,
   output logic [9:0]  out_pix,
   output logic [9:0]  out_x,
   output logic [9:0]  out_y,
   output logic        stat_valid,
   output logic [19:0] edge_count
);

   localparam int         START = SIZE_X * SIZE_Y - LAG;
   localparam logic [9:0] X0    = 10'(START % SIZE_X);
   localparam logic [9:0] Y0    = 10'(START / SIZE_X);
   localparam logic [9:0] XMAX  = 10'(SIZE_X - 1);
   localparam logic [9:0] YMAX  = 10'(SIZE_Y - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PRIME  = 2'd1,
      ACTIVE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [9:0]  px_q, px_d;
   logic [9:0]  py_q, py_d;
   logic [19:0] acc_q, acc_d;

   logic        out_valid_q, out_valid_d;
   logic [9:0]  out_pix_q, out_pix_d;
   logic [9:0]  out_x_q, out_x_d;
   logic [9:0]  out_y_q, out_y_d;
   logic        stat_valid_q, stat_valid_d;
   logic [19:0] edge_count_q, edge_count_d;

   // sof overrides the stored context so a coincident valid sample is sample 0.
   state_t      cur_state;
   logic [9:0]  cur_x;
   logic [9:0]  cur_y;
   logic [19:0] cur_acc;
   logic        border;
   logic        last_pix;
   logic        hit;
   logic        keep;

   always_comb begin
      cur_state = sof ? PRIME : state_q;
      cur_x     = sof ? X0 : px_q;
      cur_y     = sof ? Y0 : py_q;
      cur_acc   = sof ? 20'd0 : acc_q;

      border   = (cur_x == 10'd0) || (cur_x == XMAX) ||
                 (cur_y == 10'd0) || (cur_y == YMAX);
      last_pix = (cur_x == XMAX) && (cur_y == YMAX);
      hit      = (in_pix >= thresh);
      keep     = (cur_state == ACTIVE) && !border && hit;
   end

   always_comb begin
      state_d      = cur_state;
      px_d         = cur_x;
      py_d         = cur_y;
      acc_d        = cur_acc;
      out_valid_d  = 1'b0;
      out_pix_d    = 10'd0;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      stat_valid_d = 1'b0;
      edge_count_d = edge_count_q;

      if (in_valid) begin
         out_valid_d = 1'b1;
         out_x_d     = cur_x;
         out_y_d     = cur_y;
         if (keep) begin
            out_pix_d = mode ? 10'h3FF : in_pix;
         end

         if (cur_x == XMAX) begin
            px_d = 10'd0;
            py_d = (cur_y == YMAX) ? 10'd0 : cur_y + 10'd1;
         end else begin
            px_d = cur_x + 10'd1;
         end

         case (cur_state)
            PRIME: begin
               if (last_pix) begin
                  state_d = ACTIVE;
               end
            end
            ACTIVE: begin
               if (keep) begin
                  acc_d = cur_acc + 20'd1;
               end
               // The last pixel is a border pixel, so cur_acc is already the final total.
               if (last_pix) begin
                  edge_count_d = cur_acc;
                  stat_valid_d = 1'b1;
                  acc_d        = 20'd0;
               end
            end
            default: begin
               state_d = cur_state;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         px_q         <= 10'd0;
         py_q         <= 10'd0;
         acc_q        <= 20'd0;
         out_valid_q  <= 1'b0;
         out_pix_q    <= 10'd0;
         out_x_q      <= 10'd0;
         out_y_q      <= 10'd0;
         stat_valid_q <= 1'b0;
         edge_count_q <= 20'd0;
      end else begin
         state_q      <= state_d;
         px_q         <= px_d;
         py_q         <= py_d;
         acc_q        <= acc_d;
         out_valid_q  <= out_valid_d;
         out_pix_q    <= out_pix_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         stat_valid_q <= stat_valid_d;
         edge_count_q <= edge_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_pix    = out_pix_q;
   assign out_x      = out_x_q;
   assign out_y      = out_y_q;
   assign stat_valid = stat_valid_q;
   assign edge_count = edge_count_q;

endmodule

// File: tb/tb_sobel_edge_post.sv
// tb/tb_sobel_edge_post.sv - self-checking bench for sobel_edge_post
// Frame-position model derived from sample counts; expected outputs queued at drive time.

module tb_sobel_edge_post;

   localparam int SX    = 8;
   localparam int SY    = 6;
   localparam int LG    = 13;
   localparam int FSIZE = SX * SY;
   localparam int S0    = FSIZE - LG;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        sof = 1'b0;
   logic        in_valid = 1'b0;
   logic [9:0]  in_pix = 10'd0;
   logic [9:0]  thresh = 10'd0;
   logic        mode = 1'b0;
   logic        out_valid;
   logic [9:0]  out_pix;
   logic [9:0]  out_x;
   logic [9:0]  out_y;
   logic        stat_valid;
   logic [19:0] edge_count;

   sobel_edge_post #(.SIZE_X(SX), .SIZE_Y(SY), .LAG(LG)) dut (
      .clock      (clock),
      .reset      (reset),
      .sof        (sof),
      .in_valid   (in_valid),
      .in_pix     (in_pix),
      .thresh     (thresh),
      .mode       (mode),
      .out_valid  (out_valid),
      .out_pix    (out_pix),
      .out_x      (out_x),
      .out_y      (out_y),
      .stat_valid (stat_valid),
      .edge_count (edge_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        v;
      logic [9:0]  pix;
      logic [9:0]  x;
      logic [9:0]  y;
      logic        st;
      logic [19:0] cnt;
   } exp_t;

   typedef struct {
      logic       md;
      logic [9:0] pix;
      logic [9:0] th;
      bit         gap;
      int         exp_cnt;
   } vec_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail = 0;
   int   stat_seen = 0;

   // model state
   bit          m_framed = 0;
   int          m_k = 0;
   int          m_n = 0;
   int          m_acc = 0;
   logic [19:0] m_cnt = 20'd0;
   logic [9:0]  m_lx = 10'd0;
   logic [9:0]  m_ly = 10'd0;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_out();
      exp_t e;
      if (sb.size() == 0) return;
      e = sb.pop_front();
      cmp("out_valid", 32'(out_valid), 32'(e.v));
      cmp("out_pix", 32'(out_pix), 32'(e.pix));
      cmp("out_x", 32'(out_x), 32'(e.x));
      cmp("out_y", 32'(out_y), 32'(e.y));
      cmp("stat_valid", 32'(stat_valid), 32'(e.st));
      cmp("edge_count", 32'(edge_count), 32'(e.cnt));
      if (stat_valid === 1'b1) stat_seen++;
   endtask

   task automatic model(input logic r, input logic s, input logic v, input logic [9:0] pix);
      exp_t e;
      int   p;
      int   x;
      int   y;
      bit   act;
      bit   bord;
      e.v = 1'b0; e.pix = 10'd0; e.st = 1'b0;
      if (r) begin
         m_framed = 0; m_k = 0; m_n = 0; m_acc = 0; m_cnt = 20'd0;
         m_lx = 10'd0; m_ly = 10'd0;
      end else begin
         if (s) begin
            m_framed = 1; m_k = 0; m_acc = 0;
         end
         if (v) begin
            if (m_framed) begin
               p   = (S0 + m_k) % FSIZE;
               act = (m_k >= LG);
            end else begin
               p   = m_n % FSIZE;
               act = 0;
            end
            x = p % SX;
            y = p / SX;
            bord = (x == 0) || (x == SX - 1) || (y == 0) || (y == SY - 1);
            e.v = 1'b1;
            if (act && !bord && (pix >= thresh)) begin
               e.pix = mode ? 10'h3FF : pix;
               m_acc++;
            end
            if (act && p == FSIZE - 1) begin
               e.st  = 1'b1;
               m_cnt = 20'(m_acc);
               m_acc = 0;
            end
            m_k++;
            m_n++;
            m_lx = 10'(x);
            m_ly = 10'(y);
         end
      end
      e.x = m_lx;
      e.y = m_ly;
      e.cnt = m_cnt;
      sb.push_back(e);
   endtask

   task automatic step(input logic r, input logic s, input logic v, input logic [9:0] pix);
      @(negedge clock);
      check_out();
      reset = r; sof = s; in_valid = v; in_pix = pix;
      model(r, s, v, pix);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 10'd0);
      step(1'b1, 1'b0, 1'b0, 10'd0);
      stat_seen = 0;
   endtask

   vec_t vecs[7];

   initial begin
      vecs[0] = '{md: 1'b1, pix: 10'd200,  th: 10'd100,  gap: 1'b0, exp_cnt: 24};
      vecs[1] = '{md: 1'b0, pix: 10'd99,   th: 10'd100,  gap: 1'b0, exp_cnt: 0};
      vecs[2] = '{md: 1'b1, pix: 10'd200,  th: 10'd100,  gap: 1'b1, exp_cnt: 24};
      vecs[3] = '{md: 1'b0, pix: 10'd100,  th: 10'd100,  gap: 1'b0, exp_cnt: 24};
      vecs[4] = '{md: 1'b0, pix: 10'd1023, th: 10'd1023, gap: 1'b1, exp_cnt: 24};
      vecs[5] = '{md: 1'b1, pix: 10'd0,    th: 10'd0,    gap: 1'b0, exp_cnt: 24};
      vecs[6] = '{md: 1'b0, pix: 10'd0,    th: 10'd1,    gap: 1'b0, exp_cnt: 0};

      // Reset values and free-running counters without sof
      do_reset();
      step(1'b0, 1'b0, 1'b0, 10'd0);
      cmp("reset_out_valid", 32'(out_valid), 32'd0);
      cmp("reset_edge_count", 32'(edge_count), 32'd0);
      mode = 1'b1; thresh = 10'd100;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 10'd200);
      step(1'b0, 1'b0, 1'b0, 10'd0);
      cmp("idle_no_stat", 32'(stat_seen), 32'd0);

      // One frame per table row
      for (int r = 0; r < 7; r++) begin
         do_reset();
         mode = vecs[r].md; thresh = vecs[r].th;
         for (int k = 0; k <= 60; k++) begin
            step(1'b0, (k == 0), 1'b1, vecs[r].pix);
            if (vecs[r].gap) step(1'b0, 1'b0, 1'b0, 10'd0);
         end
         step(1'b0, 1'b0, 1'b0, 10'd0);
         step(1'b0, 1'b0, 1'b0, 10'd0);
         cmp("row_stat_pulses", 32'(stat_seen), 32'd1);
         cmp("row_edge_count", 32'(edge_count), 32'(vecs[r].exp_cnt));
      end

      // Second sof mid-frame restarts the frame with no pulse at the old end
      do_reset();
      mode = 1'b1; thresh = 10'd100;
      for (int k = 0; k < 30; k++) step(1'b0, (k == 0), 1'b1, 10'd200);
      for (int k = 0; k < 60; k++) step(1'b0, (k == 0), 1'b1, 10'd200);
      step(1'b0, 1'b0, 1'b0, 10'd0);
      step(1'b0, 1'b0, 1'b0, 10'd0);
      cmp("resof_no_early_stat", 32'(stat_seen), 32'd0);
      step(1'b0, 1'b0, 1'b1, 10'd200);
      step(1'b0, 1'b0, 1'b0, 10'd0);
      step(1'b0, 1'b0, 1'b0, 10'd0);
      cmp("resof_stat_after_60", 32'(stat_seen), 32'd1);
      cmp("resof_edge_count", 32'(edge_count), 32'd24);

      // Reset wins over coincident sof and in_valid mid-frame
      do_reset();
      for (int k = 0; k < 40; k++) step(1'b0, (k == 0), 1'b1, 10'd200);
      step(1'b1, 1'b1, 1'b1, 10'd200);
      step(1'b0, 1'b0, 1'b0, 10'd0);
      cmp("rst_mid_out_valid", 32'(out_valid), 32'd0);
      cmp("rst_mid_out_x", 32'(out_x), 32'd0);
      cmp("rst_mid_out_y", 32'(out_y), 32'd0);
      for (int k = 0; k < 60; k++) step(1'b0, 1'b0, 1'b1, 10'd200);
      step(1'b0, 1'b0, 1'b0, 10'd0);
      step(1'b0, 1'b0, 1'b0, 10'd0);
      cmp("rst_mid_no_stat", 32'(stat_seen), 32'd0);
      cmp("rst_mid_edge_count", 32'(edge_count), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sobel_edge_post.md
# sobel_edge_post

Post-processing stage that sits directly downstream of the Sobel filter in the camera video path. It consumes the 10-bit gradient-magnitude stream and tracks the raster position of each filter output, compensating for the filter's window latency. It forces the invalid image border to zero and thresholds the magnitude into a grey or binary edge map for the display path. It also reports a per-frame count of edge pixels.

## Interface
Parameters:
- SIZE_X, 800, active pixels per line
- SIZE_Y, 600, active lines per frame
- LAG, SIZE_X+5, valid samples between a pixel entering the filter and its magnitude arriving here; 1 ≤ LAG < SIZE_X*SIZE_Y

Ports:
- clock  in  1  master pixel clock
- reset  in  1  synchronous, active-high reset
- sof  in  1  start-of-frame pulse, one cycle, qualified by nothing; marks the first input pixel of a frame
- in_valid  in  1  magnitude sample valid; same strobe that drives the filter's control
- in_pix  in  10  gradient magnitude from the filter
- thresh  in  10  edge threshold; quasi-static, change only between frames
- mode  in  1  0 = thresholded grey, 1 = binary
- out_valid  out  1  output sample valid
- out_pix  out  10  processed pixel
- out_x  out  10  column of out_pix
- out_y  out  10  row of out_pix
- stat_valid  out  1  one-cycle pulse: edge_count updated
- edge_count  out  20  edge pixels in the last complete frame

## Operation
- Start index: S = SIZE_X*SIZE_Y − LAG; X0 = S mod SIZE_X; Y0 = S div SIZE_X. Sample number k after sof maps to frame position S+k modulo frame size.
- Position counters px/py advance on every in_valid cycle.
  - px wraps at SIZE_X−1 and then increments py.
  - py wraps at SIZE_Y−1 to 0.
- FSM states:
  - IDLE: after reset; no sof seen yet.
  - PRIME: px/py are in the previous frame's tail.
  - ACTIVE: px/py are in the current frame.
- FSM transitions:
  - sof in any state: px/py load (X0,Y0), the accumulator clears, and the state goes to PRIME. Applies equally mid-frame; no stat pulse is produced.
  - PRIME → ACTIVE when px/py wrap from (SIZE_X−1,SIZE_Y−1) to (0,0) on a valid sample.
  - ACTIVE stays ACTIVE across frame wraps.
- If sof and in_valid are both high in one cycle, that sample is sample 0 at (X0,Y0).
- Border: px==0, px==SIZE_X−1, py==0 or py==SIZE_Y−1.
- Pixel function, evaluated for each valid sample:
  - Output is 0 in IDLE, in PRIME, or when the position is a border.
  - Otherwise hit = (in_pix ≥ thresh), unsigned.
    - mode 0: out_pix = hit ? in_pix : 0.
    - mode 1: out_pix = hit ? 10'h3FF : 0.
- Statistics:
  - In ACTIVE, each non-border hit increments a 20-bit accumulator.
  - On the valid sample at (SIZE_X−1,SIZE_Y−1) in ACTIVE, edge_count loads the accumulator's final value and stat_valid pulses. The accumulator then clears for the next frame.
  - The border pixel at (SIZE_X−1,SIZE_Y−1) never counts.
- in_valid low: counters, state and accumulator all hold.

## Timing
- All outputs are registered, with a latency of 1 cycle.
  - out_valid(t+1) = in_valid(t).
  - out_pix, out_x and out_y at t+1 describe the sample of cycle t.
  - out_x/out_y show the position of that sample, including during PRIME.
- When out_valid is low, out_pix = 0; out_x/out_y hold their values.
- stat_valid is coincident with out_valid for the last-pixel sample. edge_count changes only in that cycle.
- Reset values: out_valid 0, out_pix 0, out_x 0, out_y 0, stat_valid 0, edge_count 0. Internally, px/py are 0, the accumulator is 0 and the FSM is in IDLE.
- Reset has priority over sof and in_valid in the same cycle. Reset mid-frame discards the frame with no stat pulse.
- in_valid may be gapped arbitrarily; behaviour depends only on the valid-sample count.
- No back-pressure: every input sample produces exactly one output sample.

## Test plan
All scenarios use SIZE_X=8, SIZE_Y=6, LAG=13, which gives X0=3, Y0=4.
- Reset, then 10 cycles of in_valid=1 without sof → out_valid follows in_valid one cycle later; out_pix=0 throughout; stat_valid never pulses.
- sof plus continuous valid, in_pix=200, thresh=100, mode=1 → first output at (3,4) equals 0; the first 13 outputs are 0 (PRIME); from sample 13, interior positions output 0x3FF and borders output 0; stat_valid pulses at sample 60 with edge_count=24 (6×4 interior).
- Same stream with mode=0 and in_pix=99, thresh=100 → all outputs 0; edge_count=0 at frame end.
- Same as the second scenario with in_valid toggling 1,0,1,0 → identical output sequence on valid cycles; out_pix=0 on gaps; stat_valid fires on the 61st valid input.
- Second sof at sample 30 → counters reload to (3,4); no stat pulse at the old frame end; the next pulse comes 60 valid samples after the second sof.
- Reset asserted at sample 40 while sof and in_valid are high → all outputs 0 the next cycle; FSM in IDLE; subsequent valid samples output 0 until a new sof.
